// File: rtl/isa_pkg.sv
// ISA definitions shared by the program loader and the processor's
// instruction decoder: opcode values, format classes and word width.
package isa_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_MUL  = 4'b0000;
  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_SUBI = 4'b0111;
  localparam logic [3:0] OP_B    = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_M,
    FMT_B,
    FMT_INV
  } instr_fmt_t;

  // Map an opcode onto its encoding format; 1010..1111 are unassigned.
  function automatic instr_fmt_t op_fmt(input logic [3:0] op);
    instr_fmt_t f;
    case (op)
      OP_MUL, OP_DIV, OP_ADD, OP_SUB, OP_BEQ: f = FMT_R;
      OP_ADDI, OP_SUBI:                       f = FMT_I;
      OP_LD, OP_ST:                           f = FMT_M;
      OP_B:                                   f = FMT_B;
      default:                                f = FMT_INV;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: classifies an opcode and assembles the 16-bit
// instruction word from the individual fields.
module instr_field_packer
  import isa_pkg::*;
(
  input  logic [3:0]         opcode,
  input  logic [3:0]         rd,
  input  logic [3:0]         rn,
  input  logic [3:0]         rm,
  input  logic [11:0]        imm,
  output logic [INSTR_W-1:0] word,
  output instr_fmt_t         fmt,
  output logic               range_err
);

  logic imm8_ok;

  // 8-bit immediates must be sign-extendable: bits 11..7 all equal.
  assign imm8_ok = (imm[11:7] == 5'b00000) || (imm[11:7] == 5'b11111);

  // Select the field layout for the opcode's format.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    word      = '0;
    range_err = 1'b0;
    fmt       = op_fmt(opcode);
    case (fmt)
      FMT_R: word = {opcode, rd, rn, rm};
      FMT_I: begin
        word      = {opcode, rd, imm[7:0]};
        range_err = !imm8_ok;
      end
      FMT_M: word = {opcode, imm};
      FMT_B: begin
        word      = {opcode, 4'b0000, imm[7:0]};
        range_err = !imm8_ok;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Host-side program loader: accepts field beats, packs them into
// instruction words and writes them sequentially into instruction memory,
// then raises prog_done so the core can be released.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               finish,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_opcode,
  input  logic [3:0]         in_rd,
  input  logic [3:0]         in_rn,
  input  logic [3:0]         in_rm,
  input  logic [11:0]        in_imm,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic [ADDR_W:0]    word_count,
  output logic               busy,
  output logic               prog_done,
  output logic               full,
  output logic               err_opcode,
  output logic               err_range
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [INSTR_W-1:0] word_q, word_d;
  logic               pend_q, pend_d;
  logic               err_op_q, err_op_d;
  logic               err_rng_q, err_rng_d;

  logic [INSTR_W-1:0] packed_word;
  instr_fmt_t         fmt;
  logic               range_err;
  logic               xfer;

  instr_field_packer u_packer (
    .opcode    (in_opcode),
    .rd        (in_rd),
    .rn        (in_rn),
    .rm        (in_rm),
    .imm       (in_imm),
    .word      (packed_word),
    .fmt       (fmt),
    .range_err (range_err)
  );

  assign full       = (count_q == (ADDR_W+1)'(DEPTH));
  assign in_ready   = (state_q == S_ACCEPT) && !full;
  assign xfer       = in_valid && in_ready;
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign word_count = count_q;
  assign busy       = (state_q == S_ACCEPT) || (state_q == S_WRITE);
  assign prog_done  = (state_q == S_DONE);
  assign err_opcode = err_op_q;
  assign err_range  = err_rng_q;

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    word_d    = word_q;
    pend_d    = pend_q;
    err_op_d  = err_op_q;
    err_rng_d = err_rng_q;

    case (state_q)
      S_ACCEPT: begin
        if (xfer) begin
          if (fmt == FMT_INV) begin
            err_op_d = 1'b1;
          end else if (range_err) begin
            err_rng_d = 1'b1;
          end else begin
            word_d  = packed_word;
            pend_d  = finish;
            state_d = S_WRITE;
          end
        end
        // finish without a launched write ends the program right away.
        if (finish && (state_d != S_WRITE)) state_d = S_DONE;
      end
      S_WRITE: begin
        // The address saturates at the last slot; full blocks further writes.
        if (addr_q != ADDR_W'(DEPTH - 1)) addr_d = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        pend_d  = 1'b0;
        state_d = (pend_q || finish) ? S_DONE : S_ACCEPT;
      end
      default: ;
    endcase

    // start wins over everything, including a pending finish; a write in
    // flight still completes because imem_we depends only on state_q.
    if (start) begin
      state_d   = S_ACCEPT;
      addr_d    = '0;
      count_d   = '0;
      pend_d    = 1'b0;
      err_op_d  = 1'b0;
      err_rng_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      word_q    <= '0;
      pend_q    <= 1'b0;
      err_op_q  <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      word_q    <= word_d;
      pend_q    <= pend_d;
      err_op_q  <= err_op_d;
      err_rng_q <= err_rng_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a vector table for single beats
// plus hand-written sequences for finish/start/reset/full corner cases.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, finish, in_valid;
  logic [3:0]  in_opcode, in_rd, in_rn, in_rm;
  logic [11:0] in_imm;

  logic        in_ready, imem_we, busy, prog_done, full, err_opcode, err_range;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [8:0]  word_count;

  logic        in_ready_4, imem_we_4, busy_4, prog_done_4, full_4;
  logic        err_opcode_4, err_range_4;
  logic [7:0]  imem_addr_4;
  logic [15:0] imem_wdata_4;
  logic [8:0]  word_count_4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  instr_encoder_loader dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .busy(busy), .prog_done(prog_done),
    .full(full), .err_opcode(err_opcode), .err_range(err_range)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready_4),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm(in_imm),
    .imem_we(imem_we_4), .imem_addr(imem_addr_4), .imem_wdata(imem_wdata_4),
    .word_count(word_count_4), .busy(busy_4), .prog_done(prog_done_4),
    .full(full_4), .err_opcode(err_opcode_4), .err_range(err_range_4)
  );

  typedef struct {
    logic [3:0]  op, rd, rn, rm;
    logic [11:0] imm;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [15:0] exp_word;
    logic        exp_eop, exp_erng;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [3:0] op, rd, rn, rm,
                              input logic [11:0] imm, input logic we,
                              input logic [7:0] addr, input logic [15:0] w,
                              input logic eop, erng, input logic [8:0] cnt);
    vec_t v;
    v.op = op; v.rd = rd; v.rn = rn; v.rm = rm; v.imm = imm;
    v.exp_we = we; v.exp_addr = addr; v.exp_word = w;
    v.exp_eop = eop; v.exp_erng = erng; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [3:0] op, rd, rn, rm,
                            input logic [11:0] imm);
    in_opcode = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    in_valid  = 1'b1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(4'h6, 4'h2, 4'h0, 4'h0, 12'h080, 0, 8'd0, 16'h0000, 0, 1, 9'd0);
    vecs[1]  = mk(4'hA, 4'h1, 4'h2, 4'h3, 12'h000, 0, 8'd0, 16'h0000, 1, 1, 9'd0);
    vecs[2]  = mk(4'h4, 4'h1, 4'h2, 4'h3, 12'h000, 1, 8'd0, 16'h4123, 1, 1, 9'd1);
    vecs[3]  = mk(4'h6, 4'h5, 4'h0, 4'h0, 12'hFFD, 1, 8'd1, 16'h65FD, 1, 1, 9'd2);
    vecs[4]  = mk(4'h2, 4'hF, 4'hF, 4'hF, 12'hABC, 1, 8'd2, 16'h2ABC, 1, 1, 9'd3);
    vecs[5]  = mk(4'h8, 4'hF, 4'h0, 4'h0, 12'h010, 1, 8'd3, 16'h8010, 1, 1, 9'd4);
    vecs[6]  = mk(4'h5, 4'hF, 4'hE, 4'hD, 12'h000, 1, 8'd4, 16'h5FED, 1, 1, 9'd5);
    vecs[7]  = mk(4'h0, 4'h7, 4'h8, 4'h9, 12'h000, 1, 8'd5, 16'h0789, 1, 1, 9'd6);
    vecs[8]  = mk(4'h9, 4'hA, 4'hB, 4'hC, 12'h000, 1, 8'd6, 16'h9ABC, 1, 1, 9'd7);
    vecs[9]  = mk(4'h7, 4'h2, 4'h0, 4'h0, 12'hF80, 1, 8'd7, 16'h7280, 1, 1, 9'd8);
    vecs[10] = mk(4'h3, 4'h0, 4'h0, 4'h0, 12'h800, 1, 8'd8, 16'h3800, 1, 1, 9'd9);
    vecs[11] = mk(4'h8, 4'h0, 4'h0, 4'h0, 12'h07F, 1, 8'd9, 16'h807F, 1, 1, 9'd10);
    vecs[12] = mk(4'hF, 4'h0, 4'h0, 4'h0, 12'h000, 0, 8'd0, 16'h0000, 1, 1, 9'd10);
    vecs[13] = mk(4'h8, 4'h0, 4'h0, 4'h0, 12'hF7F, 0, 8'd0, 16'h0000, 1, 1, 9'd10);

    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_opcode = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_imem_we",    32'(imem_we),    32'd0);
    check("rst_imem_addr",  32'(imem_addr),  32'd0);
    check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_prog_done",  32'(prog_done),  32'd0);
    check("rst_full",       32'(full),       32'd0);
    check("rst_errs",       32'({err_opcode, err_range}), 32'd0);
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Program load from the vector table.
    pulse_start();
    check("accept_in_ready", 32'(in_ready), 32'd1);
    check("accept_busy",     32'(busy),     32'd1);
    for (int i = 0; i < 14; i++) begin
      drive_beat(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_we", i), 32'(imem_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
        check($sformatf("v%0d_wdata", i), 32'(imem_wdata), 32'(vecs[i].exp_word));
      end
      check($sformatf("v%0d_err_opcode", i), 32'(err_opcode), 32'(vecs[i].exp_eop));
      check($sformatf("v%0d_err_range", i), 32'(err_range), 32'(vecs[i].exp_erng));
      tick();
      check($sformatf("v%0d_count", i), 32'(word_count), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
    end

    // finish with no transfer ends the program; a later finish is ignored.
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check("done_prog_done", 32'(prog_done),  32'd1);
    check("done_busy",      32'(busy),       32'd0);
    check("done_in_ready",  32'(in_ready),   32'd0);
    check("done_count",     32'(word_count), 32'd10);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check("done_finish_ignored", 32'(prog_done), 32'd1);

    // start clears errors, counters and prog_done.
    pulse_start();
    check("restart_errs",      32'({err_opcode, err_range}), 32'd0);
    check("restart_prog_done", 32'(prog_done),  32'd0);
    check("restart_count",     32'(word_count), 32'd0);
    check("restart_busy",      32'(busy),       32'd1);

    // finish in the same cycle as a transfer: write first, then DONE.
    drive_beat(4'h5, 4'h1, 4'h1, 4'h1, 12'h000);
    finish = 1'b1;
    tick();
    in_valid = 1'b0; finish = 1'b0;
    check("fin_xfer_we",        32'(imem_we),    32'd1);
    check("fin_xfer_addr",      32'(imem_addr),  32'd0);
    check("fin_xfer_wdata",     32'(imem_wdata), 32'h5111);
    check("fin_xfer_done_early", 32'(prog_done), 32'd0);
    tick();
    check("fin_xfer_prog_done", 32'(prog_done),  32'd1);
    check("fin_xfer_count",     32'(word_count), 32'd1);
    check("fin_xfer_we_off",    32'(imem_we),    32'd0);
    pulse_start();
    check("done_start_count", 32'(word_count), 32'd0);
    check("done_start_addr",  32'(imem_addr),  32'd0);

    // start during WRITE: write completes, counters restart from 0.
    drive_beat(4'h0, 4'h1, 4'h2, 4'h3, 12'h000);
    tick();
    in_valid = 1'b0;
    check("wr_start_we", 32'(imem_we), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wr_start_busy",  32'(busy),       32'd1);
    check("wr_start_count", 32'(word_count), 32'd0);
    check("wr_start_addr",  32'(imem_addr),  32'd0);
    check("wr_start_we_off", 32'(imem_we),   32'd0);
    drive_beat(4'h1, 4'h4, 4'h5, 4'h6, 12'h000);
    tick();
    in_valid = 1'b0;
    check("wr_start_next_addr",  32'(imem_addr),  32'd0);
    check("wr_start_next_wdata", 32'(imem_wdata), 32'h1456);
    tick();

    // DEPTH=4 instance: four writes, then full blocks the fifth beat.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      drive_beat(4'h4, 4'(i), 4'h0, 4'h0, 12'h000);
      tick();
      in_valid = 1'b0;
      check($sformatf("d4_w%0d_we", i), 32'(imem_we_4), 32'd1);
      check($sformatf("d4_w%0d_addr", i), 32'(imem_addr_4), 32'(i));
      check($sformatf("d4_w%0d_wdata", i), 32'(imem_wdata_4), 32'h4000 | (32'(i) << 8));
      tick();
    end
    check("d4_full",     32'(full_4),       32'd1);
    check("d4_in_ready", 32'(in_ready_4),   32'd0);
    check("d4_count",    32'(word_count_4), 32'd4);
    drive_beat(4'h4, 4'h9, 4'h0, 4'h0, 12'h000);
    tick();
    in_valid = 1'b0;
    check("d4_fifth_we",    32'(imem_we_4),    32'd0);
    check("d4_fifth_errs",  32'({err_opcode_4, err_range_4}), 32'd0);
    tick();
    check("d4_fifth_count", 32'(word_count_4), 32'd4);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check("d4_prog_done", 32'(prog_done_4), 32'd1);

    // Reset during WRITE aborts everything.
    pulse_start();
    drive_beat(4'h4, 4'h1, 4'h2, 4'h3, 12'h000);
    tick();
    in_valid = 1'b0;
    check("rstw_we_before", 32'(imem_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_we",        32'(imem_we),    32'd0);
    check("rstw_count",     32'(word_count), 32'd0);
    check("rstw_addr",      32'(imem_addr),  32'd0);
    check("rstw_wdata",     32'(imem_wdata), 32'd0);
    check("rstw_busy",      32'(busy),       32'd0);
    check("rstw_in_ready",  32'(in_ready),   32'd0);
    check("rstw_prog_done", 32'(prog_done),  32'd0);
    tick();
    check("rstw_idle_ready", 32'(in_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
